vid_scanout: RTL
================

VID_SCANOUT -- requirements
Module: vid_scanout

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line; SHALL be a multiple of 8.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal porch and sync widths in pixels.
REQ-003 Parameter V_ROWS, default 200, bitmap rows per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 12 / 2 / 35, vertical porch and sync heights in scanlines.
REQ-005 Port clk, input, 1: single clock; RAM port B also runs on it.
REQ-006 Port reset, input, 1: one clock; reset is synchronous and active-high.
REQ-007 Port pix_ce, input, 1: pixel enable; all timing advances only on clk edges with pix_ce=1.
REQ-008 Port ram_adb, output, 14: video RAM port-B byte address.
REQ-009 Port ram_ceb, output, 1: RAM port-B clock enable; also drives oceb.
REQ-010 Port ram_doutb, input, 8: RAM port-B read data; valid 2 clk after address (pipelined read).
REQ-011 Port hsync_n / vsync_n, output, 1 each: active-low syncs.
REQ-012 Port de, output, 1: display enable, high for visible pixels.
REQ-013 Port pix, output, 1: monochrome pixel; 0 whenever de=0.
REQ-014 Port frame_start, output, 1: one-clk pulse, qualified by pix_ce, at first visible pixel of a frame.

Function
REQ-015 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP=800) on pix_ce, then wrap to 0 and advance v_cnt.
REQ-016 v_cnt SHALL count 0..V_TOTAL-1, V_TOTAL=V_LINES+V_FP+V_SYNC+V_BP; V_LINES given by REQ-035/036; wrap to 0.
REQ-017 Internal active: h_cnt<H_ACTIVE and v_cnt<V_LINES; hsync active when h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync likewise on v_cnt.
REQ-018 On active line, when h_cnt=8k (k=0..H_ACTIVE/8-1) with pix_ce, ram_adb SHALL become line_base+k and ram_ceb SHALL be 1 for that clk.
REQ-019 Byte SHALL be captured from ram_doutb on the pix_ce at h_cnt=8k+7; this requires at least 2 clk between address and capture; pix_ce duty any value <=1.
REQ-020 Captured byte SHALL load into 8-bit shift register on pix_ce at h_cnt=8k+8, shifting out MSB first, one bit per pix_ce.
REQ-021 hsync_n, vsync_n, de, frame_start SHALL be delayed 8 pix_ce through a pipeline so pix bit 7 of byte k aligns with de's 8k-th visible pixel.
REQ-022 Fixed latency: internal counters to outputs = 8 pixel enables; syncs and de SHALL retain exact widths.
REQ-023 line_base SHALL be 0 at v_cnt=0 and increase by H_ACTIVE/8 (80) after each bitmap row completes; max address = V_ROWS*80-1 = 15999 < 16384.
REQ-024 ram_ceb SHALL be 0 during blanking; ram_adb holds last value.
REQ-025 pix_ce=0 SHALL freeze all counters, pipeline, shift register and outputs.

Reset
REQ-026 While reset=1 on clk: h_cnt=0, v_cnt=0, line_base=0, shift register=0, pipeline cleared.
REQ-027 Reset outputs: hsync_n=1, vsync_n=1, de=0, pix=0, frame_start=0, ram_adb=0, ram_ceb=0.
REQ-028 Reset mid-frame SHALL abort the frame; first pix_ce after release starts h_cnt=0, v_cnt=0, with frame_start 8 pix_ce later.
REQ-029 reset SHALL dominate pix_ce.

Configuration
REQ-030 Macro VID_SCANOUT_LINE_DOUBLE_EN selects scanline doubling.
REQ-035 Defined: V_LINES=2*V_ROWS (400); each bitmap row displayed on two consecutive scanlines; line_base advances after odd scanlines only; V_TOTAL=449.
REQ-036 Undefined: V_LINES=V_ROWS (200); line_base advances every active scanline; V_TOTAL=249.

Verification
REQ-031 Reset held 5 clk, pix_ce=1 -> all outputs at REQ-027 values; after release, first ram_ceb=1 with ram_adb=0 at pix_ce 0, frame_start at pix_ce 8.
REQ-032 RAM preloaded addr 0=0xA5, addr 1=0xFF, pix_ce=1 -> first 16 visible pix = 1,0,1,0,0,1,0,1,1,1,1,1,1,1,1,1.
REQ-033 pix_ce=1 every 3rd clk -> identical pixel sequence and sync counts as REQ-032; hsync_n low 96 pix_ce per line.
REQ-034 Full frame, doubling defined -> 400 de lines, scanlines 0 and 1 read addresses 0..79, last line reads 15920..15999, vsync_n low 2 lines, frame repeats every 449*800 pix_ce; undefined -> 200 de lines, 249 lines total.
REQ-037 reset asserted at line 100 pixel 300 -> outputs reset next clk; next frame restarts at address 0 with correct frame_start.

Source files
------------

// File: rtl/vid_scanout.sv
// vid_scanout: monochrome bitmap scan-out with VGA-style sync timing and a pipelined RAM read.
// Define VID_SCANOUT_LINE_DOUBLE_EN to show each bitmap row on two consecutive scanlines.
module vid_scanout #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ROWS   = 200,
  parameter int unsigned V_FP     = 12,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 35
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_ce,
  output logic [13:0] ram_adb,
  output logic        ram_ceb,
  input  logic [7:0]  ram_doutb,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        de,
  output logic        pix,
  output logic        frame_start
);

`ifdef VID_SCANOUT_LINE_DOUBLE_EN
  localparam bit          DOUBLE  = 1'b1;
  localparam int unsigned V_LINES = 2 * V_ROWS;
`else
  localparam bit          DOUBLE  = 1'b0;
  localparam int unsigned V_LINES = V_ROWS;
`endif

  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL   = V_LINES + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW        = $clog2(H_TOTAL);
  localparam int unsigned VW        = $clog2(V_TOTAL);
  localparam int unsigned PIPE      = 8;
  localparam logic [13:0] ROW_BYTES = 14'(H_ACTIVE / 8);

  logic [HW-1:0]     r_h_cnt;
  logic [VW-1:0]     r_v_cnt;
  logic [13:0]       r_line_base;
  logic [13:0]       r_ram_adb;
  logic              r_ram_ceb;
  logic [7:0]        r_shift;
  logic [4*PIPE-1:0] r_pipe;

  logic [31:0] w_h;
  logic [31:0] w_v;
  logic        w_h_act;
  logic        w_v_act;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_hs;
  logic        w_vs;
  logic        w_fs;
  logic        w_fetch;
  logic        w_load;
  logic        w_row_done;
  logic [3:0]  w_stage;
  logic [3:0]  w_out;

  assign w_h        = 32'(r_h_cnt);
  assign w_v        = 32'(r_v_cnt);
  assign w_h_act    = w_h < H_ACTIVE;
  assign w_v_act    = w_v < V_LINES;
  assign w_h_last   = w_h == H_TOTAL - 1;
  assign w_v_last   = w_v == V_TOTAL - 1;
  assign w_hs       = (w_h >= H_ACTIVE + H_FP) && (w_h < H_ACTIVE + H_FP + H_SYNC);
  assign w_vs       = (w_v >= V_LINES + V_FP) && (w_v < V_LINES + V_FP + V_SYNC);
  assign w_fs       = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign w_fetch    = w_h_act && w_v_act && (r_h_cnt[2:0] == 3'd0);
  assign w_load     = w_h_act && w_v_act && (r_h_cnt[2:0] == 3'd7);
  assign w_row_done = w_v_act && (!DOUBLE || r_v_cnt[0]);

  // Pipeline entry order {frame_start, de, hsync, vsync}; the last stage is the output register.
  assign w_stage = {w_fs, w_h_act & w_v_act, w_hs, w_vs};
  assign w_out   = r_pipe[4*PIPE-1 -: 4];

  // Byte k is loaded at the edge of h_cnt=8k+7 so its MSB is on pix while de shows pixel 8k.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_line_base <= '0;
      r_ram_adb   <= '0;
      r_ram_ceb   <= 1'b0;
      r_shift     <= '0;
      r_pipe      <= '0;
    end else begin
      r_ram_ceb <= 1'b0;
      if (pix_ce) begin
        r_pipe <= {r_pipe[4*PIPE-5:0], w_stage};
        if (w_load) begin
          r_shift <= ram_doutb;
        end else begin
          r_shift <= {r_shift[6:0], 1'b0};
        end
        if (w_fetch) begin
          r_ram_adb <= r_line_base + 14'(r_h_cnt[HW-1:3]);
          r_ram_ceb <= 1'b1;
        end
        if (w_h_last) begin
          r_h_cnt <= '0;
          if (w_v_last) begin
            r_v_cnt     <= '0;
            r_line_base <= '0;
          end else begin
            r_v_cnt <= r_v_cnt + VW'(1);
            if (w_row_done) begin
              r_line_base <= r_line_base + ROW_BYTES;
            end
          end
        end else begin
          r_h_cnt <= r_h_cnt + HW'(1);
        end
      end
    end
  end

  assign ram_adb     = r_ram_adb;
  assign ram_ceb     = r_ram_ceb;
  assign de          = w_out[2];
  assign hsync_n     = ~w_out[1];
  assign vsync_n     = ~w_out[0];
  assign pix         = r_shift[7] & w_out[2];
  assign frame_start = w_out[3] & pix_ce;

endmodule
